odu_chid_rd_scheduler: RTL and testbench
========================================

Name: odu_chid_rd_scheduler

Overview:
- Round-robin read scheduler that shares one downstream ODU data path between NUM_CH channel-ID generator FIFOs.
- Each FIFO holds 387-bit words: {valid, frame_start, row_start, data[383:0]}.
- The block issues per-channel read enables in bursts, captures the selected FIFO output and presents it on one registered output stream tagged with its channel number.
- It sits between the per-channel count/generate/FIFO blocks and the ODU framer.

Parameters:
- NUM_CH, 4, number of requesting channel FIFOs (2..16).
- BURST_LEN, 8, maximum words read from one channel per grant (1..255).
- WORD_W, 387, FIFO word width; bit 386 = valid, 385 = frame_start, 384 = row_start, 383:0 = data.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  global scheduling enable.
- ch_fifo_empty  in  NUM_CH  per-channel FIFO empty flag; bit i = channel i.
- ch_fifo_data  in  NUM_CH*WORD_W  per-channel FIFO r_data; channel i occupies bits [i*WORD_W +: WORD_W].
- ch_fifo_read_enable  out  NUM_CH  per-channel read strobe; at most one bit high per cycle.
- out_ready  in  1  downstream can accept a word two cycles later.
- out_data  out  384  scheduled payload.
- out_valid  out  1  out_data/flags/chid qualify this cycle.
- out_frame_start  out  1  frame_start bit of the presented word.
- out_row_start  out  1  row_start bit of the presented word.
- out_chid  out  clog2(NUM_CH)  channel that sourced the presented word.
- busy  out  1  high while in BURST state.

Behaviour:
- Reset (async, rst=1): FSM=IDLE, rr_ptr=0, grant=0, burst count=0, ch_fifo_read_enable=0, all out_* = 0, busy=0. Outputs are forced to these values immediately on rst assertion and persist until the first clk edge after release.
- Reset mid-burst: the burst is abandoned, any in-flight word is discarded (not presented), and rr_ptr returns to 0.
- FIFO timing: r_data for channel i is valid on the cycle after its read_enable was high.
- IDLE state:
  - If enable=1 and any ch_fifo_empty bit=0: select the first non-empty channel searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., NUM_CH-1, 0, ...).
  - Latch it as grant, clear the burst count, go to BURST.
  - No read is issued in IDLE. Every grant change therefore costs exactly one idle cycle.
- BURST state: ch_fifo_read_enable[grant] = out_ready & enable & ~ch_fifo_empty[grant]. This is combinational and drives no other bits. Each issued read increments the count.
- Burst end: go to IDLE and set rr_ptr = (grant+1) mod NUM_CH on the first of these:
  - count reaches BURST_LEN (after the BURST_LEN-th read);
  - ch_fifo_empty[grant]=1 with no read issued that cycle;
  - enable=0.
- Burst stall: out_ready=0 with the FIFO non-empty stalls the burst. The FSM stays in BURST, no read is issued, the count holds and the grant is not released.
- Output pipeline:
  - Read strobe at cycle t: FIFO word sampled at the end of cycle t+1 together with a delayed copy of grant; the word is presented at cycle t+2.
  - out_valid = delayed read strobe & word bit 386.
  - out_frame_start and out_row_start = word bits 385/384, gated by out_valid.
  - On cycles with no presented word: out_valid=0, flags=0, out_data and out_chid hold their last values.
- Fixed latency: 2 cycles from read strobe to out_valid. Back-to-back reads give back-to-back outputs. Downstream must accept any word presented.
- Count width: clog2(BURST_LEN+1). The count never wraps because the burst ends at BURST_LEN.
- A single non-empty channel is re-granted after one idle cycle. With NUM_CH=1 the rr_ptr wrap yields 0.
- Fairness: with all channels continuously non-empty and out_ready=1, the grant order is 0,1,...,NUM_CH-1,0,... with BURST_LEN words each.

Test Plan:
- Reset: rst=1 asynchronously mid-clock -> all outputs 0 immediately. After release with all FIFOs empty and enable=1 -> no read strobes and busy=0 for 20 cycles.
- Single channel: only ch2 holds 20 words, out_ready=1 -> strobes on ch2 in runs of 8, 8, 4, each run preceded by one idle cycle. 20 outputs with out_chid=2, each 2 cycles after its strobe, and the payload order preserved.
- Fairness: all 4 FIFOs full, out_ready=1 -> out_chid sequence 0×8, 1×8, 2×8, 3×8, 0×8. No cycle has more than one read_enable bit set.
- Empty mid-burst: ch1 holds 3 words, ch3 holds 10 words, rr_ptr=1 -> ch1 burst ends after 3 reads, IDLE for 1 cycle, then ch3 is granted. ch1 is not re-granted while ch3 is non-empty and rr_ptr=0 (after the ch3 burst) still skips to ch3 correctly.
- Backpressure: out_ready dropped for 5 cycles mid-burst -> no strobes, count frozen and grant kept. On resume the burst completes exactly 8 total words for that channel.
- Enable drop / reset mid-burst: enable=0 after 4 reads of ch0 -> FSM to IDLE, rr_ptr=1, the 4 issued words are still presented. Same point with rst pulse instead -> outputs cleared, no pending word presented, first grant after release goes to ch0.

Source files
------------

// File: rtl/odu_chid_rd_scheduler.sv
// rtl/odu_chid_rd_scheduler.sv - round-robin burst read scheduler for channel-ID FIFOs
// Grants one FIFO at a time, reads up to BURST_LEN words, presents them two cycles after the strobe.
module odu_chid_rd_scheduler #(
   parameter int NUM_CH    = 4,
   parameter int BURST_LEN = 8,
   parameter int WORD_W    = 387,
   localparam int CHW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic [NUM_CH-1:0]        ch_fifo_empty,
   input  logic [NUM_CH*WORD_W-1:0] ch_fifo_data,
   output logic [NUM_CH-1:0]        ch_fifo_read_enable,
   input  logic                     out_ready,
   output logic [WORD_W-4:0]        out_data,
   output logic                     out_valid,
   output logic                     out_frame_start,
   output logic                     out_row_start,
   output logic [CHW-1:0]           out_chid,
   output logic                     busy
);

   localparam int CNTW   = $clog2(BURST_LEN + 1);
   localparam int DATA_W = WORD_W - 3;

   typedef enum logic {ST_IDLE, ST_BURST} state_t;

   state_t              state_q, state_d;
   logic [CHW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [CHW-1:0]      grant_q, grant_d;
   logic [CNTW-1:0]     count_q, count_d;
   logic                rd_dly_q, rd_dly_d;
   logic [CHW-1:0]      grant_dly_q, grant_dly_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic [CHW-1:0]      out_chid_q, out_chid_d;
   logic                out_valid_q, out_valid_d;
   logic                out_fs_q, out_fs_d;
   logic                out_rs_q, out_rs_d;

   logic                rd_fire;
   logic                pick_found;
   logic [CHW-1:0]      pick_ch;
   logic [CHW-1:0]      cand;
   logic [CHW-1:0]      next_ptr;
   logic [WORD_W-1:0]   sel_word;
   logic [WORD_W-1:0]   ch_word [NUM_CH];

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_word
      assign ch_word[gi] = ch_fifo_data[gi*WORD_W +: WORD_W];
   end

   assign sel_word = ch_word[grant_dly_q];
   assign rd_fire  = (state_q == ST_BURST) & out_ready & enable & ~ch_fifo_empty[grant_q];
   assign next_ptr = (grant_q == CHW'(NUM_CH - 1)) ? '0 : grant_q + CHW'(1);

   // First non-empty channel at or above rr_ptr, wrapping past the top.
   always_comb begin
      pick_found = 1'b0;
      pick_ch    = '0;
      cand       = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         cand = CHW'((int'(rr_ptr_q) + k) % NUM_CH);
         if (!pick_found && !ch_fifo_empty[cand]) begin
            pick_found = 1'b1;
            pick_ch    = cand;
         end
      end
   end

   always_comb begin
      ch_fifo_read_enable = '0;
      if (rd_fire) ch_fifo_read_enable[grant_q] = 1'b1;
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = grant_q;
      count_d  = count_q;
      case (state_q)
         ST_IDLE: begin
            if (enable && pick_found) begin
               grant_d = pick_ch;
               count_d = '0;
               state_d = ST_BURST;
            end
         end
         ST_BURST: begin
            if (!enable || ch_fifo_empty[grant_q]) begin
               state_d  = ST_IDLE;
               rr_ptr_d = next_ptr;
            end else if (out_ready) begin
               count_d = count_q + CNTW'(1);
               if (count_d == CNTW'(BURST_LEN)) begin
                  state_d  = ST_IDLE;
                  rr_ptr_d = next_ptr;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FIFO data lags its strobe by a cycle, so the grant travels alongside the strobe.
   always_comb begin
      rd_dly_d    = rd_fire;
      grant_dly_d = grant_q;
      out_valid_d = rd_dly_q & sel_word[WORD_W-1];
      out_fs_d    = out_valid_d & sel_word[WORD_W-2];
      out_rs_d    = out_valid_d & sel_word[WORD_W-3];
      out_data_d  = rd_dly_q ? sel_word[DATA_W-1:0] : out_data_q;
      out_chid_d  = rd_dly_q ? grant_dly_q : out_chid_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         grant_q     <= '0;
         count_q     <= '0;
         rd_dly_q    <= 1'b0;
         grant_dly_q <= '0;
         out_data_q  <= '0;
         out_chid_q  <= '0;
         out_valid_q <= 1'b0;
         out_fs_q    <= 1'b0;
         out_rs_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_q     <= grant_d;
         count_q     <= count_d;
         rd_dly_q    <= rd_dly_d;
         grant_dly_q <= grant_dly_d;
         out_data_q  <= out_data_d;
         out_chid_q  <= out_chid_d;
         out_valid_q <= out_valid_d;
         out_fs_q    <= out_fs_d;
         out_rs_q    <= out_rs_d;
      end
   end

   assign out_data        = out_data_q;
   assign out_chid        = out_chid_q;
   assign out_valid       = out_valid_q;
   assign out_frame_start = out_fs_q;
   assign out_row_start   = out_rs_q;
   assign busy            = (state_q == ST_BURST);

endmodule

// File: tb/tb_odu_chid_rd_scheduler.sv
// tb/tb_odu_chid_rd_scheduler.sv - randomized bench for odu_chid_rd_scheduler
// FIFO contents and the strobe/output schedule are predicted from queue counts before each run.
module tb_odu_chid_rd_scheduler;

   localparam int NUM_CH = 4;
   localparam int BL     = 8;
   localparam int WORD_W = 387;
   localparam int MAXC   = 256;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     enable;
   logic [NUM_CH-1:0]        ch_fifo_empty;
   logic [NUM_CH*WORD_W-1:0] ch_fifo_data;
   logic [NUM_CH-1:0]        ch_fifo_read_enable;
   logic                     out_ready;
   logic [383:0]             out_data;
   logic                     out_valid;
   logic                     out_frame_start;
   logic                     out_row_start;
   logic [1:0]               out_chid;
   logic                     busy;

   odu_chid_rd_scheduler #(.NUM_CH(NUM_CH), .BURST_LEN(BL), .WORD_W(WORD_W)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .enable              (enable),
      .ch_fifo_empty       (ch_fifo_empty),
      .ch_fifo_data        (ch_fifo_data),
      .ch_fifo_read_enable (ch_fifo_read_enable),
      .out_ready           (out_ready),
      .out_data            (out_data),
      .out_valid           (out_valid),
      .out_frame_start     (out_frame_start),
      .out_row_start       (out_row_start),
      .out_chid            (out_chid),
      .busy                (busy)
   );

   always #5 clk = ~clk;

   logic [WORD_W-1:0] fq [NUM_CH][$];
   logic [WORD_W-1:0] fdata [NUM_CH];

   always_comb begin
      ch_fifo_data = '0;
      for (int i = 0; i < NUM_CH; i++) ch_fifo_data[i*WORD_W +: WORD_W] = fdata[i];
   end

   bit                sch_rdy [MAXC];
   bit                sch_en  [MAXC];
   logic [NUM_CH-1:0] a_rd    [MAXC];
   logic              a_busy  [MAXC];
   logic              a_val   [MAXC];
   logic              a_fs    [MAXC];
   logic              a_rs    [MAXC];
   logic [383:0]      a_data  [MAXC];
   logic [1:0]        a_chid  [MAXC];
   int                p_rd    [MAXC];
   bit                p_busy  [MAXC];
   logic [WORD_W-1:0] p_word  [MAXC];

   int n_vec  = 0;
   int n_fail = 0;

   function automatic logic [WORD_W-1:0] rand_word(input bit allow_invalid);
      logic [WORD_W-1:0] w;
      for (int k = 0; k < 12; k++) w[k*32 +: 32] = $urandom;
      w[384] = 1'($urandom_range(0, 1));
      w[385] = 1'($urandom_range(0, 1));
      w[386] = allow_invalid ? ($urandom_range(0, 7) != 0) : 1'b1;
      return w;
   endfunction

   task automatic update_empty();
      for (int i = 0; i < NUM_CH; i++) ch_fifo_empty[i] = (fq[i].size() == 0);
   endtask

   task automatic load(input int n0, input int n1, input int n2, input int n3, input bit inv);
      int n [NUM_CH];
      n[0] = n0; n[1] = n1; n[2] = n2; n[3] = n3;
      for (int i = 0; i < NUM_CH; i++) begin
         fq[i].delete();
         for (int j = 0; j < n[i]; j++) fq[i].push_back(rand_word(inv));
      end
      update_empty();
   endtask

   task automatic sched(input int rdy_pct, input int en_pct);
      for (int c = 0; c < MAXC; c++) begin
         sch_rdy[c] = ($urandom_range(0, 99) < rdy_pct);
         sch_en[c]  = ($urandom_range(0, 99) < en_pct);
      end
   endtask

   task automatic reset_start();
      rst = 1'b1;
      enable = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < NUM_CH; i++) fdata[i] = '0;
   endtask

   task automatic reset_end();
      @(posedge clk);
      #2 rst = 1'b0;
   endtask

   // Reference: idle cycle picks a channel round-robin; a burst reads while ready, stops on
   // BL words, an empty FIFO seen on a no-read cycle, or enable low.
   task automatic predict(input int n, input int ptr0);
      int cnt [NUM_CH];
      int pidx [NUM_CH];
      bit in_burst;
      int grant, done, ptr, pick;
      for (int i = 0; i < NUM_CH; i++) begin cnt[i] = fq[i].size(); pidx[i] = 0; end
      in_burst = 0; grant = 0; done = 0; ptr = ptr0;
      for (int c = 0; c < n; c++) begin
         p_rd[c] = -1;
         p_busy[c] = in_burst;
         p_word[c] = '0;
         if (!in_burst) begin
            pick = -1;
            for (int k = 0; k < NUM_CH; k++)
               if (pick < 0 && cnt[(ptr + k) % NUM_CH] > 0) pick = (ptr + k) % NUM_CH;
            if (sch_en[c] && pick >= 0) begin grant = pick; done = 0; in_burst = 1; end
         end else if (!sch_en[c] || cnt[grant] == 0) begin
            in_burst = 0; ptr = (grant + 1) % NUM_CH;
         end else if (sch_rdy[c]) begin
            p_rd[c] = grant;
            p_word[c] = fq[grant][pidx[grant]];
            pidx[grant]++; cnt[grant]--; done++;
            if (done == BL) begin in_burst = 0; ptr = (grant + 1) % NUM_CH; end
         end
      end
   endtask

   task automatic run(input int n);
      for (int c = 0; c < n; c++) begin
         out_ready = sch_rdy[c];
         enable = sch_en[c];
         @(negedge clk);
         a_rd[c] = ch_fifo_read_enable; a_busy[c] = busy; a_val[c] = out_valid;
         a_fs[c] = out_frame_start; a_rs[c] = out_row_start;
         a_data[c] = out_data; a_chid[c] = out_chid;
         @(posedge clk);
         #1;
         for (int i = 0; i < NUM_CH; i++)
            if (a_rd[c][i] && fq[i].size() > 0) fdata[i] = fq[i].pop_front();
         update_empty();
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; enable = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < NUM_CH; i++) fdata[i] = '0;
      load(0, 0, 0, 0, 0);
      #12 rst = 1'b1;
      #1;
      n_vec++;
      if ({ch_fifo_read_enable, busy, out_valid, out_frame_start, out_row_start, out_chid, out_data} !== '0) begin
         n_fail++;
         $display("FAIL reset_async outputs got %h exp 0",
                  {ch_fifo_read_enable, busy, out_valid, out_frame_start, out_row_start, out_chid});
      end
      reset_end();
      sched(100, 100);
      predict(20, 0);
      run(20);
      for (int c = 0; c < 20; c++) begin
         n_vec++;
         if ({a_rd[c], a_busy[c], a_val[c]} !== {NUM_CH'(0), 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_idle c=%0d rd,busy,valid got %b exp 0", c, {a_rd[c], a_busy[c], a_val[c]});
         end
      end
   endtask

   task automatic test_single_channel();
      reset_start(); load(0, 0, 20, 0, 0); reset_end();
      sched(100, 100); predict(30, 0); run(30);
      for (int c = 0; c < 30; c++) begin
         logic [NUM_CH+3:0] ev, av;
         logic [WORD_W-1:0] w;
         bit pv;
         pv = 0; w = '0;
         if (c >= 2) if (p_rd[c-2] >= 0) begin w = p_word[c-2]; pv = w[386]; end
         ev = {(p_rd[c] >= 0) ? (NUM_CH'(1) << p_rd[c]) : NUM_CH'(0), p_busy[c], pv, pv & w[385], pv & w[384]};
         av = {a_rd[c], a_busy[c], a_val[c], a_fs[c], a_rs[c]};
         n_vec++;
         if (av !== ev) begin n_fail++; $display("FAIL single c=%0d rd,busy,v,fs,rs got %b exp %b", c, av, ev); end
         if (pv) begin
            n_vec++;
            if ({a_chid[c], a_data[c]} !== {2'(p_rd[c-2]), w[383:0]}) begin
               n_fail++;
               $display("FAIL single_data c=%0d got %0d/%h exp %0d/%h", c, a_chid[c], a_data[c], p_rd[c-2], w[383:0]);
            end
         end
      end
   endtask

   task automatic test_fairness();
      int seq [$];
      reset_start(); load(20, 20, 20, 20, 0); reset_end();
      sched(100, 100); predict(120, 0); run(120);
      for (int c = 0; c < 120; c++) begin
         logic [NUM_CH+3:0] ev, av;
         logic [WORD_W-1:0] w;
         bit pv;
         pv = 0; w = '0;
         if (c >= 2) if (p_rd[c-2] >= 0) begin w = p_word[c-2]; pv = w[386]; end
         ev = {(p_rd[c] >= 0) ? (NUM_CH'(1) << p_rd[c]) : NUM_CH'(0), p_busy[c], pv, pv & w[385], pv & w[384]};
         av = {a_rd[c], a_busy[c], a_val[c], a_fs[c], a_rs[c]};
         n_vec++;
         if (av !== ev) begin n_fail++; $display("FAIL fair c=%0d rd,busy,v,fs,rs got %b exp %b", c, av, ev); end
         n_vec++;
         if ($countones(a_rd[c]) > 1) begin n_fail++; $display("FAIL fair_onehot c=%0d got %b exp <=1 bit", c, a_rd[c]); end
         if (pv) begin
            n_vec++;
            if ({a_chid[c], a_data[c]} !== {2'(p_rd[c-2]), w[383:0]}) begin
               n_fail++;
               $display("FAIL fair_data c=%0d got %0d/%h exp %0d/%h", c, a_chid[c], a_data[c], p_rd[c-2], w[383:0]);
            end
         end
         if (a_val[c]) seq.push_back(int'(a_chid[c]));
      end
      for (int k = 0; k < 40; k++) begin
         n_vec++;
         if (k >= seq.size()) begin
            n_fail++; $display("FAIL fair_order k=%0d got none exp %0d", k, (k / BL) % NUM_CH);
         end else if (seq[k] != (k / BL) % NUM_CH) begin
            n_fail++; $display("FAIL fair_order k=%0d got %0d exp %0d", k, seq[k], (k / BL) % NUM_CH);
         end
      end
   endtask

   task automatic test_empty_mid_burst();
      reset_start(); load(0, 3, 0, 10, 0); reset_end();
      sched(100, 100); predict(40, 0); run(40);
      for (int c = 0; c < 40; c++) begin
         logic [NUM_CH+3:0] ev, av;
         logic [WORD_W-1:0] w;
         bit pv;
         pv = 0; w = '0;
         if (c >= 2) if (p_rd[c-2] >= 0) begin w = p_word[c-2]; pv = w[386]; end
         ev = {(p_rd[c] >= 0) ? (NUM_CH'(1) << p_rd[c]) : NUM_CH'(0), p_busy[c], pv, pv & w[385], pv & w[384]};
         av = {a_rd[c], a_busy[c], a_val[c], a_fs[c], a_rs[c]};
         n_vec++;
         if (av !== ev) begin n_fail++; $display("FAIL empty_mid c=%0d rd,busy,v,fs,rs got %b exp %b", c, av, ev); end
         if (pv) begin
            n_vec++;
            if ({a_chid[c], a_data[c]} !== {2'(p_rd[c-2]), w[383:0]}) begin
               n_fail++;
               $display("FAIL empty_mid_data c=%0d got %0d/%h exp %0d/%h", c, a_chid[c], a_data[c], p_rd[c-2], w[383:0]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int ch0_first;
      reset_start(); load(12, 8, 0, 0, 0); reset_end();
      sched(100, 100);
      for (int c = 4; c < 9; c++) sch_rdy[c] = 0;
      predict(50, 0); run(50);
      ch0_first = 0;
      for (int c = 0; c < 50 && !a_rd[c][1]; c++) if (a_rd[c][0]) ch0_first++;
      n_vec++;
      if (ch0_first != BL) begin n_fail++; $display("FAIL bp_burst_len got %0d exp %0d", ch0_first, BL); end
      for (int c = 0; c < 50; c++) begin
         logic [NUM_CH+3:0] ev, av;
         logic [WORD_W-1:0] w;
         bit pv;
         pv = 0; w = '0;
         if (c >= 2) if (p_rd[c-2] >= 0) begin w = p_word[c-2]; pv = w[386]; end
         ev = {(p_rd[c] >= 0) ? (NUM_CH'(1) << p_rd[c]) : NUM_CH'(0), p_busy[c], pv, pv & w[385], pv & w[384]};
         av = {a_rd[c], a_busy[c], a_val[c], a_fs[c], a_rs[c]};
         n_vec++;
         if (av !== ev) begin n_fail++; $display("FAIL bp c=%0d rd,busy,v,fs,rs got %b exp %b", c, av, ev); end
         if (pv) begin
            n_vec++;
            if ({a_chid[c], a_data[c]} !== {2'(p_rd[c-2]), w[383:0]}) begin
               n_fail++;
               $display("FAIL bp_data c=%0d got %0d/%h exp %0d/%h", c, a_chid[c], a_data[c], p_rd[c-2], w[383:0]);
            end
         end
      end
   endtask

   task automatic test_enable_drop();
      int ch0_first;
      reset_start(); load(10, 5, 0, 0, 0); reset_end();
      sched(100, 100);
      sch_en[5] = 0; sch_en[6] = 0;
      predict(40, 0); run(40);
      ch0_first = 0;
      for (int c = 0; c < 40 && !a_rd[c][1]; c++) if (a_rd[c][0]) ch0_first++;
      n_vec++;
      if (ch0_first != 4) begin n_fail++; $display("FAIL en_drop_reads got %0d exp 4", ch0_first); end
      for (int c = 0; c < 40; c++) begin
         logic [NUM_CH+3:0] ev, av;
         logic [WORD_W-1:0] w;
         bit pv;
         pv = 0; w = '0;
         if (c >= 2) if (p_rd[c-2] >= 0) begin w = p_word[c-2]; pv = w[386]; end
         ev = {(p_rd[c] >= 0) ? (NUM_CH'(1) << p_rd[c]) : NUM_CH'(0), p_busy[c], pv, pv & w[385], pv & w[384]};
         av = {a_rd[c], a_busy[c], a_val[c], a_fs[c], a_rs[c]};
         n_vec++;
         if (av !== ev) begin n_fail++; $display("FAIL en_drop c=%0d rd,busy,v,fs,rs got %b exp %b", c, av, ev); end
         if (pv) begin
            n_vec++;
            if ({a_chid[c], a_data[c]} !== {2'(p_rd[c-2]), w[383:0]}) begin
               n_fail++;
               $display("FAIL en_drop_data c=%0d got %0d/%h exp %0d/%h", c, a_chid[c], a_data[c], p_rd[c-2], w[383:0]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      reset_start(); load(10, 5, 0, 0, 0); reset_end();
      sched(100, 100); run(5);
      rst = 1'b1;
      #1;
      n_vec++;
      if ({ch_fifo_read_enable, busy, out_valid, out_frame_start, out_row_start, out_chid, out_data} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_clear got rd=%b busy=%b v=%b chid=%0d data=%h exp 0",
                  ch_fifo_read_enable, busy, out_valid, out_chid, out_data);
      end
      reset_end();
      predict(30, 0); run(30);
      for (int c = 0; c < 30; c++) begin
         logic [NUM_CH+3:0] ev, av;
         logic [WORD_W-1:0] w;
         bit pv;
         pv = 0; w = '0;
         if (c >= 2) if (p_rd[c-2] >= 0) begin w = p_word[c-2]; pv = w[386]; end
         ev = {(p_rd[c] >= 0) ? (NUM_CH'(1) << p_rd[c]) : NUM_CH'(0), p_busy[c], pv, pv & w[385], pv & w[384]};
         av = {a_rd[c], a_busy[c], a_val[c], a_fs[c], a_rs[c]};
         n_vec++;
         if (av !== ev) begin n_fail++; $display("FAIL reset_mid c=%0d rd,busy,v,fs,rs got %b exp %b", c, av, ev); end
         if (pv) begin
            n_vec++;
            if ({a_chid[c], a_data[c]} !== {2'(p_rd[c-2]), w[383:0]}) begin
               n_fail++;
               $display("FAIL reset_mid_data c=%0d got %0d/%h exp %0d/%h", c, a_chid[c], a_data[c], p_rd[c-2], w[383:0]);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 4; r++) begin
         reset_start();
         load($urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 20), 1);
         reset_end();
         sched(80, 95); predict(200, 0); run(200);
         for (int c = 0; c < 200; c++) begin
            logic [NUM_CH+3:0] ev, av;
            logic [WORD_W-1:0] w;
            bit pv;
            pv = 0; w = '0;
            if (c >= 2) if (p_rd[c-2] >= 0) begin w = p_word[c-2]; pv = w[386]; end
            ev = {(p_rd[c] >= 0) ? (NUM_CH'(1) << p_rd[c]) : NUM_CH'(0), p_busy[c], pv, pv & w[385], pv & w[384]};
            av = {a_rd[c], a_busy[c], a_val[c], a_fs[c], a_rs[c]};
            n_vec++;
            if (av !== ev) begin n_fail++; $display("FAIL random r=%0d c=%0d rd,busy,v,fs,rs got %b exp %b", r, c, av, ev); end
            if (pv) begin
               n_vec++;
               if ({a_chid[c], a_data[c]} !== {2'(p_rd[c-2]), w[383:0]}) begin
                  n_fail++;
                  $display("FAIL random_data r=%0d c=%0d got %0d/%h exp %0d/%h", r, c, a_chid[c], a_data[c], p_rd[c-2], w[383:0]);
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_channel();
      test_fairness();
      test_empty_mid_burst();
      test_backpressure();
      test_enable_drop();
      test_reset_mid_burst();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
